sec_countdown: RTL and testbench
================================

# sec_countdown

Seconds-resolution countdown timer consuming the one-cycle 1 Hz strobe produced by the design's seconds timer. Holds a BCD MM:SS value, decrements it on each strobe while running, and reports expiry with a single-cycle pulse. It feeds the VGA overlay text renderer with BCD digits and the game/control logic with run and expiry status.

## Interface
- CLK_FREQ, 25_000_000, clock frequency in Hz; used only when the internal prescaler is compiled in.
- MAX_MIN, 99, largest loadable minute value in binary (1..99).
- iClk  in  1  system clock, all logic on rising edge.
- iRst  in  1  asynchronous, active-low reset.
- iTick  in  1  one-cycle 1 Hz strobe; ignored when SEC_COUNTDOWN_PRESCALE_EN is defined.
- iLoad  in  1  one-cycle load request.
- iLoadMin  in  8  BCD minutes for load (two digits).
- iLoadSec  in  8  BCD seconds for load (two digits).
- iStart  in  1  one-cycle start/resume request.
- iPause  in  1  one-cycle pause request.
- oMin  out  8  current BCD minutes.
- oSec  out  8  current BCD seconds.
- oRunning  out  1  high in RUN.
- oDone  out  1  one-cycle pulse when the count reaches 00:00.
- oErr  out  1  one-cycle pulse when a load is rejected.

## Operation
- States: IDLE, RUN, PAUSE, EXPIRED. Reset: IDLE, oMin=oSec=8'h00, oRunning=0, oDone=0, oErr=0.
- Request priority within one cycle: iLoad > iPause > iStart. Lower-priority requests are dropped.
- Load is valid only if every nibble is <= 9, iLoadSec <= 8'h59, and minutes <= MAX_MIN. If valid, the value is written and the state goes to IDLE from any state. If invalid, the value and state are unchanged and oErr pulses.
- iStart: IDLE or PAUSE -> RUN if the value is not 00:00. Otherwise it is ignored. In RUN or EXPIRED it is ignored.
- iPause: RUN -> PAUSE. It is ignored in all other states.
- In RUN, a tick decrements the value by one second:
  - A seconds units digit of 0 wraps to 9 and borrows from the seconds tens digit.
  - Seconds 00 wraps to 59 and borrows one minute.
- A decrement that produces 00:00 moves the state to EXPIRED and raises oDone for exactly that cycle.
- In EXPIRED, the value holds at 00:00 and only iLoad has an effect.
- Ticks outside RUN are ignored. A tick in the same cycle as a load or pause is ignored. A tick in the same cycle as start is ignored: counting begins on the next tick.

## Timing
- All outputs are registered. The value, state and pulses update on the first rising edge after the request or tick is sampled. Latency is 1 cycle.
- oDone and oErr are high for exactly one cycle and never high together.
- oRunning is high exactly while the state is RUN.
- Reset asserted mid-count forces the reset values immediately (asynchronously). Deassertion is synchronised externally.
- Back-to-back requests on consecutive cycles are each honoured. No request is lost except by the priority rule.

## Configuration
- Macro: SEC_COUNTDOWN_PRESCALE_EN.
- Defined:
  - An internal counter, modulo CLK_FREQ and $clog2(CLK_FREQ) bits wide, generates the tick; iTick is unused.
  - The counter clears on any accepted load or start, so the first decrement comes exactly CLK_FREQ cycles after start.
  - The counter freezes in PAUSE.
- Undefined: no prescaler logic is built, and decrements occur only on iTick.

## Structure
- Shared package sec_countdown_pkg contains:
  - the state enum (IDLE, RUN, PAUSE, EXPIRED);
  - BCD constants BCD_ZERO=8'h00 and SEC_WRAP=8'h59;
  - a BCD-nibble validity function.
- One sub-module, bcd_dec2, is instantiated twice (seconds, minutes):
  - Inputs: 8-bit BCD value, decrement enable, wrap value.
  - Outputs: the decremented value and a borrow out.
  - Combinational: 00 with enable yields the wrap value plus borrow.

## Test plan
- Load 01:30, start, 3 ticks -> oMin=8'h01, oSec=8'h27, oRunning=1.
- Load 01:00, start, 1 tick -> 00:59, no oDone.
- Load 00:02, start, 2 ticks -> oDone one cycle with 00:00, state EXPIRED; further ticks and iStart leave 00:00 and oDone low.
- Load 00:10, start, 2 ticks, pause, 5 ticks, start, 1 tick -> 00:07; iLoad with iPause and iTick in the same cycle loads and drops both.
- Load iLoadSec=8'h60, then iLoadMin=8'h1A -> oErr pulses each time, value unchanged; start on 00:00 leaves IDLE.
- Reset asserted mid-RUN at 00:45 -> all outputs zero immediately; with SEC_COUNTDOWN_PRESCALE_EN and CLK_FREQ=10, load 00:03 and start -> oDone exactly 30 cycles after start.

Source files
------------

// File: rtl/sec_countdown_pkg.sv
// Shared types, BCD constants and helpers for the sec_countdown timer.
package sec_countdown_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PAUSE   = 2'd2,
        EXPIRED = 2'd3
    } state_t;

    localparam logic [7:0] BCD_ZERO = 8'h00;
    localparam logic [7:0] SEC_WRAP = 8'h59;

    function automatic logic bcdNibbleOk(input logic [3:0] nib);
        return (nib <= 4'd9);
    endfunction

    function automatic logic [7:0] bcdToBin(input logic [7:0] bcd);
        return ({4'd0, bcd[7:4]} * 8'd10) + {4'd0, bcd[3:0]};
    endfunction

endpackage

// File: rtl/sec_countdown_bcd_dec2.sv
// Two-digit BCD decrementer: 00 with enable yields the wrap value and a borrow.
module bcd_dec2
    import sec_countdown_pkg::*;
(
    input  logic [7:0] iVal,
    input  logic       iEn,
    input  logic [7:0] iWrap,
    output logic [7:0] oVal,
    output logic       oBorrow
);

    // Digit-wise decrement with units-to-tens borrow
    always_comb begin
        oVal    = iVal;
        oBorrow = 1'b0;
        if (!iEn) begin
            oVal    = iVal;
            oBorrow = 1'b0;
        end else if (iVal == BCD_ZERO) begin
            oVal    = iWrap;
            oBorrow = 1'b1;
        end else if (iVal[3:0] == 4'd0) begin
            oVal    = {iVal[7:4] - 4'd1, 4'd9};
            oBorrow = 1'b0;
        end else begin
            oVal    = {iVal[7:4], iVal[3:0] - 4'd1};
            oBorrow = 1'b0;
        end
    end

endmodule

// File: rtl/sec_countdown.sv
// BCD MM:SS countdown timer driven by a 1 Hz strobe.
// Define SEC_COUNTDOWN_PRESCALE_EN to generate the strobe internally from CLK_FREQ.
module sec_countdown
    import sec_countdown_pkg::*;
#(
    parameter int CLK_FREQ = 25_000_000,
    parameter int MAX_MIN  = 99
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       iTick,
    input  logic       iLoad,
    input  logic [7:0] iLoadMin,
    input  logic [7:0] iLoadSec,
    input  logic       iStart,
    input  logic       iPause,
    output logic [7:0] oMin,
    output logic [7:0] oSec,
    output logic       oRunning,
    output logic       oDone,
    output logic       oErr
);

    state_t     state, nState;
    logic [7:0] nMin, nSec, secDec, minDec;
    logic       nDone, nErr;
    logic       tickSrc, doDec, secBorrow, minBorrow;
    logic       loadOk, loadAccept, startAccept, valueZero;

    assign valueZero = (oMin == BCD_ZERO) && (oSec == BCD_ZERO);
    assign loadOk    = bcdNibbleOk(iLoadMin[7:4]) && bcdNibbleOk(iLoadMin[3:0]) &&
                       bcdNibbleOk(iLoadSec[7:4]) && bcdNibbleOk(iLoadSec[3:0]) &&
                       (iLoadSec <= SEC_WRAP) && (bcdToBin(iLoadMin) <= 8'(MAX_MIN));
    assign loadAccept  = iLoad && loadOk;
    assign startAccept = !iLoad && !iPause && iStart && !valueZero &&
                         ((state == IDLE) || (state == PAUSE));
    assign doDec = (state == RUN) && tickSrc && !iLoad && !iPause && !iStart;

`ifdef SEC_COUNTDOWN_PRESCALE_EN
    localparam int CW = (CLK_FREQ > 1) ? $clog2(CLK_FREQ) : 1;
    logic [CW-1:0] preCnt;

    assign tickSrc = (preCnt == CW'(CLK_FREQ - 1));

    // Prescaler: restarts on load/start, advances only while running
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            preCnt <= '0;
        end else if (loadAccept || startAccept) begin
            preCnt <= '0;
        end else if (state == RUN) begin
            preCnt <= tickSrc ? '0 : preCnt + CW'(1);
        end else begin
            preCnt <= preCnt;
        end
    end
`else
    assign tickSrc = iTick && (CLK_FREQ > 0);
`endif

    bcd_dec2 uSecDec (
        .iVal    (oSec),
        .iEn     (doDec),
        .iWrap   (SEC_WRAP),
        .oVal    (secDec),
        .oBorrow (secBorrow)
    );

    bcd_dec2 uMinDec (
        .iVal    (oMin),
        .iEn     (secBorrow),
        .iWrap   (BCD_ZERO),
        .oVal    (minDec),
        .oBorrow (minBorrow)
    );

    // Next-state, next-value and pulse decode in request priority order
    always_comb begin
        nState = state;
        nMin   = oMin;
        nSec   = oSec;
        nDone  = 1'b0;
        nErr   = 1'b0;
        if (iLoad) begin
            if (loadOk) begin
                nMin   = iLoadMin;
                nSec   = iLoadSec;
                nState = IDLE;
            end else begin
                nErr = 1'b1;
            end
        end else if (iPause) begin
            if (state == RUN) begin
                nState = PAUSE;
            end else begin
                nState = state;
            end
        end else if (iStart) begin
            if (startAccept) begin
                nState = RUN;
            end else begin
                nState = state;
            end
        end else if (doDec) begin
            // A minute underflow can only mean a corrupted value; clamp to expiry
            if (minBorrow || ((minDec == BCD_ZERO) && (secDec == BCD_ZERO))) begin
                nMin   = BCD_ZERO;
                nSec   = BCD_ZERO;
                nState = EXPIRED;
                nDone  = 1'b1;
            end else begin
                nMin = minDec;
                nSec = secDec;
            end
        end else begin
            nState = state;
        end
    end

    // State and registered outputs
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state    <= IDLE;
            oMin     <= BCD_ZERO;
            oSec     <= BCD_ZERO;
            oRunning <= 1'b0;
            oDone    <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            state    <= nState;
            oMin     <= nMin;
            oSec     <= nSec;
            oRunning <= (nState == RUN);
            oDone    <= nDone;
            oErr     <= nErr;
        end
    end

endmodule

// File: tb/tb_sec_countdown.sv
// Directed self-checking bench for sec_countdown.
module tb_sec_countdown;

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic       iTick = 1'b0, iLoad = 1'b0, iStart = 1'b0, iPause = 1'b0;
    logic [7:0] iLoadMin = 8'h00, iLoadSec = 8'h00;
    logic [7:0] oMin, oSec;
    logic       oRunning, oDone, oErr;
    int         total = 0;
    int         bad = 0;

    always #5 iClk = ~iClk;

    sec_countdown #(.CLK_FREQ(10), .MAX_MIN(99)) dut (
        .iClk     (iClk),
        .iRst     (iRst),
        .iTick    (iTick),
        .iLoad    (iLoad),
        .iLoadMin (iLoadMin),
        .iLoadSec (iLoadSec),
        .iStart   (iStart),
        .iPause   (iPause),
        .oMin     (oMin),
        .oSec     (oSec),
        .oRunning (oRunning),
        .oDone    (oDone),
        .oErr     (oErr)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply one cycle of requests, then sample 1 time unit after the edge
    task automatic doStep(input logic ld, input logic [7:0] lm, input logic [7:0] ls,
                          input logic st, input logic ps, input logic tk);
        iLoad = ld; iLoadMin = lm; iLoadSec = ls;
        iStart = st; iPause = ps; iTick = tk;
        @(posedge iClk); #1;
        iLoad = 1'b0; iStart = 1'b0; iPause = 1'b0; iTick = 1'b0;
    endtask

    task automatic checkOut(input string tag, input logic [7:0] m, input logic [7:0] s,
                            input logic r, input logic d, input logic e);
        checkVal({tag, ".value"}, {16'd0, oMin, oSec}, {16'd0, m, s});
        checkVal({tag, ".flags"}, {29'd0, oRunning, oDone, oErr}, {29'd0, r, d, e});
    endtask

    initial begin
        #2;
        checkOut("reset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge iClk); iRst = 1'b1;
        @(posedge iClk); #1;
`ifndef SEC_COUNTDOWN_PRESCALE_EN
        doStep(1'b1, 8'h01, 8'h30, 1'b0, 1'b0, 1'b0);
        checkOut("load0130", 8'h01, 8'h30, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOut("start0130", 8'h01, 8'h30, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("tick3", 8'h01, 8'h27, 1'b1, 1'b0, 1'b0);

        doStep(1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOut("load0100", 8'h01, 8'h00, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("minBorrow", 8'h00, 8'h59, 1'b1, 1'b0, 1'b0);

        doStep(1'b1, 8'h10, 8'h00, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("tensBorrow", 8'h09, 8'h59, 1'b1, 1'b0, 1'b0);

        doStep(1'b1, 8'h00, 8'h02, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("tick0001", 8'h00, 8'h01, 1'b1, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("expire", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOut("donePulse", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("expTick", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOut("expStart", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        doStep(1'b1, 8'h00, 8'h10, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 2; i++) doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("unitsWrap", 8'h00, 8'h08, 1'b1, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        checkOut("pause", 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("pausedTicks", 8'h00, 8'h08, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b1);
        checkOut("resumeTick", 8'h00, 8'h08, 1'b1, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("resumed", 8'h00, 8'h07, 1'b1, 1'b0, 1'b0);
        doStep(1'b1, 8'h02, 8'h22, 1'b0, 1'b1, 1'b1);
        checkOut("loadWins", 8'h02, 8'h22, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1);
        checkOut("idleTick", 8'h02, 8'h22, 1'b0, 1'b0, 1'b0);

        doStep(1'b1, 8'h00, 8'h60, 1'b0, 1'b0, 1'b0);
        checkOut("errSec60", 8'h02, 8'h22, 1'b0, 1'b0, 1'b1);
        doStep(1'b1, 8'h1A, 8'h00, 1'b0, 1'b0, 1'b0);
        checkOut("errMin1A", 8'h02, 8'h22, 1'b0, 1'b0, 1'b1);
        doStep(1'b1, 8'h00, 8'h0B, 1'b0, 1'b0, 1'b0);
        checkOut("errSecUnits", 8'h02, 8'h22, 1'b0, 1'b0, 1'b1);
        doStep(1'b1, 8'h99, 8'h59, 1'b0, 1'b0, 1'b0);
        checkOut("loadMax", 8'h99, 8'h59, 1'b0, 1'b0, 1'b0);
        doStep(1'b1, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOut("startZero", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);

        doStep(1'b1, 8'h00, 8'h45, 1'b0, 1'b0, 1'b0);
        doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
        checkOut("run0045", 8'h00, 8'h45, 1'b1, 1'b0, 1'b0);
        #2 iRst = 1'b0;
        #1;
        checkOut("asyncReset", 8'h00, 8'h00, 1'b0, 1'b0, 1'b0);
        @(negedge iClk); iRst = 1'b1;
        @(posedge iClk); #1;
`else
        begin
            int n;
            n = 0;
            doStep(1'b1, 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
            checkOut("pLoad", 8'h00, 8'h03, 1'b0, 1'b0, 1'b0);
            doStep(1'b0, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0);
            checkOut("pStart", 8'h00, 8'h03, 1'b1, 1'b0, 1'b0);
            for (int i = 1; i <= 100; i++) begin
                @(posedge iClk); #1;
                if (oDone) begin
                    n = i;
                    break;
                end
            end
            checkVal("pDoneCycle", n, 32'd30);
            checkOut("pExpired", 8'h00, 8'h00, 1'b0, 1'b1, 1'b0);
        end
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
